regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2-read/1-write 64-bit file used in the single-cycle datapath. It provides NREAD combinational read ports, NWRITE prioritised write ports, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit for hazard detection. After reset it clears itself sequentially, one register per cycle, and signals `ready` when the clear is complete. Register 0 always reads 0.

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of 2, ≥ 8); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (≥ 1)
- NWRITE, 2, number of write ports (≥ 1)
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value
- TEST_INIT, 0, 1 = the init sequence loads register k with value k for k = 1..7; all other registers get 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- raddr  in  NREAD*AW  read addresses; port p uses bits [p*AW +: AW]
- rdata  out  NREAD*XLEN  read data; port p uses bits [p*XLEN +: XLEN]
- rpending  out  NREAD  pending bit of the register addressed by each read port
- we  in  NWRITE  write enables
- waddr  in  NWRITE*AW  write addresses
- wdata  in  NWRITE*XLEN  write data
- alloc_valid  in  1  reserve a destination register (sets its pending bit)
- alloc_addr  in  AW  register to reserve
- ready  out  1  init complete; file accepts writes and allocations

## Operation
- States: INIT and RUN. A rising edge with rst=1 enters INIT, sets init_idx=0, clears every pending bit, and forces ready=0.
- INIT: each edge with rst=0 writes the init value to reg[init_idx] and increments init_idx. The edge that writes reg[NREGS-1] moves the FSM to RUN and sets ready=1.
- During INIT, we and alloc_valid are ignored. Every rdata reads 0 and every rpending reads 0.
- RUN, write: for each port w with we[w]=1 and waddr≠0, reg[waddr] ← wdata on the edge and pending[waddr] is cleared. If several ports target the same address, the highest-index port wins.
- RUN, alloc: if alloc_valid=1 and alloc_addr≠0, pending[alloc_addr] is set. If a write and an alloc target the same register on the same edge, the data is written and pending ends up 1 (alloc wins).
- Read: port p returns 0 if raddr_p=0. Otherwise it returns the stored value, except when BYPASS=1, in RUN, and some enabled write targets raddr_p: then it returns that write's wdata, using the highest-index matching port.
- rpending_p = pending[raddr_p]. It is not bypassed; it shows the registered state.
- Writes and allocs to register 0 are dropped; pending[0] is always 0.
- Reset mid-operation: the edge with rst=1 drops any same-edge write or alloc, and init restarts from index 0.

## Timing
- Reset values: ready=0 and all pending bits=0. rdata=0 and rpending=0 until ready=1.
- ready rises on the NREGS-th rising edge after the first edge sampling rst=0 (32 edges by default). It stays 1 until the next rst.
- Read latency is 0 cycles (combinational from raddr, and from we/waddr/wdata when BYPASS=1).
- Write latency: the new value is visible on the stored path after 1 edge.
- Alloc latency: pending becomes visible on rpending after 1 edge.
- There is no back-pressure. Every write and alloc presented in RUN completes in one cycle.

## Test plan
- Reset and init with TEST_INIT=1: assert rst for 2 cycles, then release. Required: ready=0 for exactly 32 edges, then 1. Afterwards raddr0=5 reads 0x5, raddr1=9 reads 0x0, and rdata stays 0 throughout INIT.
- Dual-write conflict: we=2'b11, waddr0=waddr1=10, wdata0=0xAAAA, wdata1=0x5555. Next cycle, reading 10 returns 0x5555. Repeat with waddr=0: reading 0 returns 0.
- Bypass: with BYPASS=1, set we0=1, waddr0=3, wdata0=0xDEADBEEF and raddr0=3 in the same cycle. Required: rdata0=0xDEADBEEF in that cycle. With BYPASS=0, rdata0 returns the old value 0x3 in that cycle and 0xDEADBEEF in the next.
- Scoreboard: alloc x12, then rpending for x12 is 1 for 3 idle cycles. A write to x12 makes it 0 on the next cycle. A simultaneous alloc and write on x12 leaves it 1 with the new data stored. Alloc of x0 leaves rpending=0.
- Ignored during init: assert we and alloc_valid on x4 during INIT. Required: after ready, x4 holds its init value and pending[4]=0.
- Reset mid-run: set x20=0x77 and pending[20]=1, then pulse rst for 1 cycle with a same-cycle write to x21. Required: ready=0 for 32 edges, after which x20=0, x21=0, and pending[20]=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with prioritised writes, optional write-to-read bypass,
// a per-register pending scoreboard, and a sequential self-clear after reset.
module regfile_mp #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 2,
  parameter int BYPASS    = 1,
  parameter int TEST_INIT = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*XLEN-1:0]  rdata,
  output logic [NREAD-1:0]       rpending,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic                   alloc_valid,
  input  logic [AW-1:0]          alloc_addr,
  output logic                   ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     init_idx, init_idx_next;
  logic [XLEN-1:0]   init_val;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
    end
  end

  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    if (state == INIT) begin
      init_idx_next = init_idx + 1'b1;
      if (init_idx == AW'(NREGS - 1)) state_next = RUN;
    end
  end

  assign ready = (state == RUN);

  // Test images preload x1..x7 with their own index so reads are recognisable.
  assign init_val = (TEST_INIT != 0 && init_idx >= AW'(1) && init_idx <= AW'(7))
                    ? XLEN'(init_idx) : '0;

  // Ascending port order lets the highest-index writer land last and win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        regs[init_idx] <= init_val;
      end else begin
        for (int w = 0; w < NWRITE; w++) begin
          if (we[w] && waddr[w*AW +: AW] != '0)
            regs[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Alloc is applied after the write clears so a same-edge alloc leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (state == RUN) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (we[w] && waddr[w*AW +: AW] != '0)
          pending[waddr[w*AW +: AW]] <= 1'b0;
      end
      if (alloc_valid && alloc_addr != '0)
        pending[alloc_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[p*AW +: AW];

    always_comb begin
      rd = regs[ra];
      if (BYPASS != 0 && state == RUN) begin
        for (int w = 0; w < NWRITE; w++) begin
          if (we[w] && waddr[w*AW +: AW] == ra)
            rd = wdata[w*XLEN +: XLEN];
        end
      end
      if (ra == '0 || state != RUN) rd = '0;
    end

    assign rdata[p*XLEN +: XLEN] = rd;
    assign rpending[p]           = (state == RUN) && pending[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share the
// same stimulus, both built with the test init image.
module tb_regfile_mp;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata, rdata_nb;
  logic [NREAD-1:0]       rpending, rpending_nb;
  logic [NWRITE-1:0]      we;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic                   alloc_valid;
  logic [AW-1:0]          alloc_addr;
  logic                   ready, ready_nb;

  int   checks   = 0;
  int   failures = 0;
  int   edges;
  logic clean;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
               .BYPASS(1), .TEST_INIT(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rpending(rpending),
    .we(we), .waddr(waddr), .wdata(wdata), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .ready(ready)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
               .BYPASS(0), .TEST_INIT(1)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rpending(rpending_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .ready(ready_nb)
  );

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w,
                               input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                               input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                               input logic av, input logic [AW-1:0] aa,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    we          = w;
    waddr       = {wa1, wa0};
    wdata       = {wd1, wd0};
    alloc_valid = av;
    alloc_addr  = aa;
    raddr       = {ra1, ra0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(output int n, output logic init_clean);
    n          = 0;
    init_clean = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
      if (rdata != '0 || rdata_nb != '0 || rpending != '0 || rpending_nb != '0)
        init_clean = 1'b0;
    end
  endtask

  initial begin
    // Reset with writes/allocs to x4 held active through the whole init sequence
    rst = 1'b1;
    applyStimulus(2'b11, 5'd4, 64'h1111, 5'd4, 64'h2222, 1'b1, 5'd4, 5'd5, 5'd9);
    tick();
    checkOutput("reset_ready", 64'(ready), 64'd0);
    checkOutput("reset_pending", 64'(rpending), 64'd0);
    tick();
    rst = 1'b0;
    waitReady(edges, clean);
    checkOutput("init_edges", 64'(edges), 64'd32);
    checkOutput("init_reads_zero", 64'(clean), 64'd1);
    checkOutput("nb_ready", 64'(ready_nb), 64'd1);

    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    checkOutput("init_x5", rdata[XLEN-1:0], 64'h5);
    checkOutput("init_x9", rdata[2*XLEN-1:XLEN], 64'h0);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd4, 5'd7);
    checkOutput("init_x4_ignored_write", rdata[XLEN-1:0], 64'h4);
    checkOutput("init_x4_ignored_alloc", 64'(rpending[0]), 64'd0);
    checkOutput("init_x7", rdata_nb[2*XLEN-1:XLEN], 64'h7);

    // Dual-write conflict on x10: port 1 must win
    applyStimulus(2'b11, 5'd10, 64'hAAAA, 5'd10, 64'h5555, 1'b0, 5'd0, 5'd10, 5'd10);
    checkOutput("conflict_bypass", rdata[XLEN-1:0], 64'h5555);
    checkOutput("conflict_nb_old", rdata_nb[XLEN-1:0], 64'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd10, 5'd10);
    checkOutput("conflict_stored", rdata[XLEN-1:0], 64'h5555);
    checkOutput("conflict_nb_stored", rdata_nb[2*XLEN-1:XLEN], 64'h5555);

    applyStimulus(2'b11, 5'd0, 64'hAAAA, 5'd0, 64'h5555, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_write_bypass", rdata[XLEN-1:0], 64'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_after_write", rdata[XLEN-1:0], 64'h0);

    // Same-cycle bypass vs stored path on x3
    applyStimulus(2'b01, 5'd3, 64'hDEADBEEF, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    checkOutput("bypass_same_cycle", rdata[XLEN-1:0], 64'hDEADBEEF);
    checkOutput("nb_same_cycle_old", rdata_nb[XLEN-1:0], 64'h3);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    checkOutput("nb_next_cycle", rdata_nb[XLEN-1:0], 64'hDEADBEEF);
    checkOutput("bypass_next_cycle", rdata[XLEN-1:0], 64'hDEADBEEF);

    // Scoreboard on x12
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd12, 5'd0, 5'd12);
    checkOutput("alloc_pre_edge", 64'(rpending[1]), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd12);
      checkOutput($sformatf("alloc_held_%0d", i), 64'(rpending[1]), 64'd1);
      tick();
    end
    applyStimulus(2'b01, 5'd12, 64'h1234, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd12);
    checkOutput("pending_not_bypassed", 64'(rpending[1]), 64'd1);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd12);
    checkOutput("write_clears_pending", 64'(rpending[1]), 64'd0);
    checkOutput("write_x12_data", rdata_nb[2*XLEN-1:XLEN], 64'h1234);
    applyStimulus(2'b10, 5'd0, 64'h0, 5'd12, 64'h5678, 1'b1, 5'd12, 5'd0, 5'd12);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd12);
    checkOutput("alloc_wins_pending", 64'(rpending_nb[1]), 64'd1);
    checkOutput("alloc_write_data", rdata_nb[2*XLEN-1:XLEN], 64'h5678);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("alloc_x0_dropped", 64'(rpending[1]), 64'd0);

    // Reset mid-run with a same-edge write to x21
    applyStimulus(2'b01, 5'd20, 64'h77, 5'd0, 64'h0, 1'b1, 5'd20, 5'd20, 5'd21);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd20, 5'd21);
    checkOutput("midrun_x20", rdata[XLEN-1:0], 64'h77);
    checkOutput("midrun_pending20", 64'(rpending[0]), 64'd1);
    rst = 1'b1;
    applyStimulus(2'b01, 5'd21, 64'h99, 5'd0, 64'h0, 1'b0, 5'd0, 5'd20, 5'd21);
    tick();
    checkOutput("midrun_reset_ready", 64'(ready), 64'd0);
    rst = 1'b0;
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd20, 5'd21);
    waitReady(edges, clean);
    checkOutput("reinit_edges", 64'(edges), 64'd32);
    checkOutput("reinit_reads_zero", 64'(clean), 64'd1);
    #1;
    checkOutput("reinit_x20", rdata[XLEN-1:0], 64'h0);
    checkOutput("reinit_x21", rdata_nb[2*XLEN-1:XLEN], 64'h0);
    checkOutput("reinit_pending20", 64'(rpending[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
